// File: rtl/ste_shift_pkg.sv
// Shared types and helpers for the framed multi-lane shift register.
package ste_shift_pkg;

  // Shift direction; the encoding matches cfg_msb_first_i directly.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } shift_dir_e;

  // Bit n set when a lane count of n is supported (1, 2, 4, 8).
  localparam logic [8:0] LANES_LEGAL = 9'b1_0001_0110;

  function automatic bit lanes_legal(int unsigned lanes);
    if (lanes > 8) return 1'b0;
    return LANES_LEGAL[lanes[3:0]];
  endfunction

  // Frame length in steps; 0 or anything beyond a full register means a full register.
  function automatic int unsigned eff_len(int unsigned len, int unsigned steps);
    return (len == 0 || len > steps) ? steps : len;
  endfunction

endpackage

// File: rtl/ste_shift_capture.sv
// Capture register for completed frames, with valid/ack handshake and sticky overrun.
module ste_shift_capture #(
  parameter int unsigned SHIFT_W = 24
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               complete_i,
  input  logic [SHIFT_W-1:0] word_i,
  input  logic               ack_i,
  output logic [SHIFT_W-1:0] capture_o,
  output logic               capture_valid_o,
  output logic               overrun_o
);

  logic [SHIFT_W-1:0] cap_q, cap_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  // Next state: a completion wins over an ack and only flags overrun if the old word is unread.
  always_comb begin
    cap_d   = cap_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_i) ovr_d = 1'b0;
    if (complete_i) begin
      cap_d   = word_i;
      valid_d = 1'b1;
      if (valid_q && !ack_i) ovr_d = 1'b1;
    end else if (valid_q && ack_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      cap_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign capture_o       = cap_q;
  assign capture_valid_o = valid_q;
  assign overrun_o       = ovr_q;

endmodule

// File: rtl/ste_shift_reg_frame.sv
// Multi-lane, direction-selectable shift register with frame counting and word capture.
module ste_shift_reg_frame
  import ste_shift_pkg::*;
#(
  parameter  int unsigned SHIFT_W = 24,
  parameter  int unsigned LANES   = 1,
  localparam int unsigned STEPS   = SHIFT_W / LANES,
  localparam int unsigned CNT_W   = $clog2(STEPS + 1)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               cfg_msb_first_i,
  input  logic [CNT_W-1:0]   cfg_frame_len_i,
  input  logic [LANES-1:0]   din_i,
  input  logic [SHIFT_W-1:0] din_parallel_i,
  input  logic               shift_clr_i,
  input  logic               shift_en_i,
  input  logic               shift_ld_i,
  output logic [LANES-1:0]   dout_o,
  output logic [SHIFT_W-1:0] dout_parallel_o,
  output logic               frame_done_o,
  output logic [SHIFT_W-1:0] capture_o,
  output logic               capture_valid_o,
  input  logic               capture_ack_i,
  output logic               overrun_o
);

  if ((SHIFT_W % LANES) != 0) begin : g_bad_width
    $error("SHIFT_W must be a multiple of LANES");
  end
  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4 or 8");
  end

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W:0]     cnt_inc, len_eff;
  logic               complete;
  logic               done_q;
  shift_dir_e         dir;

  assign dir     = shift_dir_e'(cfg_msb_first_i);
  assign len_eff = (CNT_W + 1)'(eff_len(32'(cfg_frame_len_i), STEPS));
  // One extra bit so the compare cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  // Next register/counter value in priority order clear > load > shift.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (shift_clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_ld_i) begin
      shift_d = din_parallel_i;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      if (dir == MSB_FIRST) shift_d = {shift_q[SHIFT_W-LANES-1:0], din_i};
      else                  shift_d = {din_i, shift_q[SHIFT_W-1:LANES]};
      // >= so that shortening the frame mid-way still terminates it.
      if (cnt_inc >= len_eff) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Shift register, step counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= complete;
    end
  end

  ste_shift_capture #(
    .SHIFT_W(SHIFT_W)
  ) u_capture (
    .clk             (clk),
    .reset_i         (reset_i),
    .clr_i           (shift_clr_i),
    .complete_i      (complete),
    .word_i          (shift_d),
    .ack_i           (capture_ack_i),
    .capture_o       (capture_o),
    .capture_valid_o (capture_valid_o),
    .overrun_o       (overrun_o)
  );

  assign dout_o          = (dir == MSB_FIRST) ? shift_q[SHIFT_W-1 -: LANES] : shift_q[LANES-1:0];
  assign dout_parallel_o = shift_q;
  assign frame_done_o    = done_q;

endmodule

// File: tb/tb_ste_shift_reg_frame.sv
// Directed bench: a 1-lane instance (a) and a 4-lane instance (b) sharing clock and reset.
module tb_ste_shift_reg_frame;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: SHIFT_W=24, LANES=1 (CNT_W=5)
  logic        msb_a, clr_a, en_a, ld_a, ack_a, din_a;
  logic [4:0]  len_a;
  logic [23:0] par_a, pout_a, cap_a;
  logic        dout_a, done_a, valid_a, ovr_a;

  // Instance b: SHIFT_W=24, LANES=4 (CNT_W=3)
  logic        msb_b, clr_b, en_b, ld_b, ack_b;
  logic [3:0]  din_b, dout_b;
  logic [2:0]  len_b;
  logic [23:0] par_b, pout_b, cap_b;
  logic        done_b, valid_b, ovr_b;

  int n_cmp = 0;
  int n_err = 0;

  ste_shift_reg_frame #(.SHIFT_W(24), .LANES(1)) u_dut_a (
    .clk             (clk),
    .reset_i         (rst),
    .cfg_msb_first_i (msb_a),
    .cfg_frame_len_i (len_a),
    .din_i           (din_a),
    .din_parallel_i  (par_a),
    .shift_clr_i     (clr_a),
    .shift_en_i      (en_a),
    .shift_ld_i      (ld_a),
    .dout_o          (dout_a),
    .dout_parallel_o (pout_a),
    .frame_done_o    (done_a),
    .capture_o       (cap_a),
    .capture_valid_o (valid_a),
    .capture_ack_i   (ack_a),
    .overrun_o       (ovr_a)
  );

  ste_shift_reg_frame #(.SHIFT_W(24), .LANES(4)) u_dut_b (
    .clk             (clk),
    .reset_i         (rst),
    .cfg_msb_first_i (msb_b),
    .cfg_frame_len_i (len_b),
    .din_i           (din_b),
    .din_parallel_i  (par_b),
    .shift_clr_i     (clr_b),
    .shift_en_i      (en_b),
    .shift_ld_i      (ld_b),
    .dout_o          (dout_b),
    .dout_parallel_o (pout_b),
    .frame_done_o    (done_b),
    .capture_o       (cap_b),
    .capture_valid_o (valid_b),
    .capture_ack_i   (ack_b),
    .overrun_o       (ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] word;
    logic [23:0] exp_cap [3];
    int pulses;

    rst = 1'b1;
    {msb_a, clr_a, en_a, ld_a, ack_a, din_a} = '0;
    len_a = '0; par_a = '0;
    {msb_b, clr_b, en_b, ld_b, ack_b} = '0;
    din_b = '0; len_b = '0; par_b = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("rst_pout_a",  pout_a, 0);
    check("rst_cap_a",   cap_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_done_a",  done_a, 0);
    check("rst_ovr_a",   ovr_a, 0);
    check("rst_pout_b",  pout_b, 0);

    // 1) Full 24-step MSB-first frame with default length
    msb_a = 1'b1; len_a = 5'd0; word = 24'hDFEABC; pulses = 0;
    for (int i = 23; i >= 0; i--) begin
      din_a = word[i]; en_a = 1'b1;
      cyc();
      if (done_a) pulses++;
    end
    en_a = 1'b0;
    check("full_pulses", pulses, 1);
    check("full_done",   done_a, 1);
    check("full_cap",    cap_a, 24'hDFEABC);
    check("full_valid",  valid_a, 1);
    check("full_dout",   dout_a, 1);
    ack_a = 1'b1;
    cyc();
    ack_a = 1'b0;
    check("full_ack_valid", valid_a, 0);
    check("full_done_off",  done_a, 0);

    // 2) 4 lanes, LSB-first, low nibble first
    msb_b = 1'b0; len_b = 3'd0; word = 24'h234567; pulses = 0;
    for (int k = 0; k < 6; k++) begin
      din_b = word[4*k +: 4]; en_b = 1'b1;
      cyc();
      if (done_b && k < 5) pulses++;
    end
    en_b = 1'b0;
    check("lane_early_done", pulses, 0);
    check("lane_done",  done_b, 1);
    check("lane_cap",   cap_b, 24'h234567);
    check("lane_valid", valid_b, 1);
    par_b = 24'h234567; ld_b = 1'b1;
    cyc();
    ld_b = 1'b0;
    check("lane_dout_0", dout_b, 4'h7);
    for (int k = 1; k < 6; k++) begin
      din_b = 4'h0; en_b = 1'b1;
      cyc();
      check("lane_dout_k", dout_b, word[4*k +: 4]);
    end
    en_b = 1'b0;

    // 3) Short frames of 8 steps, ack held high throughout
    exp_cap[0] = 24'hEABCAA; exp_cap[1] = 24'hBCAAAA; exp_cap[2] = 24'hAAAAAA;
    len_a = 5'd8; ack_a = 1'b1; word = 24'hAAAAAA; pulses = 0;
    for (int i = 0; i < 24; i++) begin
      din_a = word[23-i]; en_a = 1'b1;
      cyc();
      if (done_a) begin
        check("short_done_step", i % 8, 7);
        if (pulses < 3) check("short_cap", cap_a, exp_cap[pulses]);
        pulses++;
      end
    end
    en_a = 1'b0;
    check("short_pulses", pulses, 3);
    check("short_ovr",    ovr_a, 0);
    cyc();
    ack_a = 1'b0;
    check("short_valid_clr", valid_a, 0);

    // 4) Overrun: two unacknowledged frames
    for (int i = 0; i < 8; i++) begin din_a = 1'b1; en_a = 1'b1; cyc(); end
    check("ovr_first_cap", cap_a, 24'hAAAAFF);
    check("ovr_first_ovr", ovr_a, 0);
    for (int i = 0; i < 8; i++) begin din_a = 1'b0; en_a = 1'b1; cyc(); end
    en_a = 1'b0;
    check("ovr_second_cap", cap_a, 24'hAAFF00);
    check("ovr_set",        ovr_a, 1);
    clr_a = 1'b1;
    cyc();
    clr_a = 1'b0;
    check("clr_ovr",   ovr_a, 0);
    check("clr_pout",  pout_a, 0);
    check("clr_valid", valid_a, 1);
    check("clr_cap",   cap_a, 24'hAAFF00);
    // completion coinciding with ack
    for (int i = 0; i < 8; i++) begin
      din_a = 1'b1; en_a = 1'b1; ack_a = (i == 7);
      cyc();
    end
    en_a = 1'b0; ack_a = 1'b0;
    check("ackcomp_cap",   cap_a, 24'h0000FF);
    check("ackcomp_valid", valid_a, 1);
    check("ackcomp_ovr",   ovr_a, 0);
    ack_a = 1'b1;
    cyc();
    ack_a = 1'b0;

    // 5) Priority
    par_a = 24'hA5AA5A; clr_a = 1'b1; ld_a = 1'b1; en_a = 1'b1; din_a = 1'b1;
    cyc();
    clr_a = 1'b0; ld_a = 1'b0;
    check("prio_clr", pout_a, 0);
    cyc(); cyc(); cyc();
    check("prio_pre", pout_a, 24'h000007);
    ld_a = 1'b1;
    cyc();
    ld_a = 1'b0;
    check("prio_ld",      pout_a, 24'hA5AA5A);
    check("prio_ld_done", done_a, 0);
    check("prio_ld_dout", dout_a, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      din_a = 1'b0;
      cyc();
      if (done_a && i < 7) pulses++;
    end
    en_a = 1'b0;
    check("prio_cnt_restart", pulses, 0);
    check("prio_done",        done_a, 1);
    check("prio_cap",         cap_a, 24'hAA5A00);

    // 6) Reset mid-frame
    len_a = 5'd0;
    for (int i = 0; i < 10; i++) begin din_a = 1'b1; en_a = 1'b1; cyc(); end
    en_a = 1'b0; rst = 1'b1;
    cyc();
    check("mrst_pout",  pout_a, 0);
    check("mrst_cap",   cap_a, 0);
    check("mrst_valid", valid_a, 0);
    check("mrst_done",  done_a, 0);
    check("mrst_ovr",   ovr_a, 0);
    check("mrst_dout",  dout_a, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      din_a = (i == 23); en_a = 1'b1;
      cyc();
      if (done_a && i < 23) pulses++;
    end
    en_a = 1'b0;
    check("post_early_done", pulses, 0);
    check("post_done",  done_a, 1);
    check("post_cap",   cap_a, 24'h000001);
    check("post_valid", valid_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
